// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture sequencer.
//   cap_state_e      - FSM state enum, 3-bit encoding (also exported on the debug port)
//   EDGE_RISE/FALL   - encodings of the trig_rising select input
//   AUTO_TIMEOUT_DEF - default auto-trigger timeout in valid samples
package capture_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPre      = 3'd1,
        StWaitTrig = 3'd2,
        StPost     = 3'd3,
        StDone     = 3'd4
    } cap_state_e;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    localparam int unsigned AUTO_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: sample stream in, circular-buffer write port out.
//   sample_valid - one-cycle strobe for a new decimated sample (decim_clk)
//   sample       - 8-bit decimated sample (adc_data)
//   buf_we       - buffer write enable, single-cycle pulse
//   buf_waddr    - buffer write address
//   buf_wdata    - buffer write data
// master: the capture controller; slave: the acquisition/buffer side.
interface capture_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              sample_valid;
    logic [7:0]        sample;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [7:0]        buf_wdata;

    modport master (
        input  sample_valid,
        input  sample,
        output buf_we,
        output buf_waddr,
        output buf_wdata
    );

    modport slave (
        output sample_valid,
        output sample,
        input  buf_we,
        input  buf_waddr,
        input  buf_wdata
    );
endinterface

// File: rtl/trig_detect.sv
// trig_detect: level-crossing comparator against the previous valid sample.
//   adc_dco     - clock
//   rst_n       - async active-low reset
//   clr         - forget the previous sample (new capture armed)
//   upd         - current sample is consumed; becomes prev
//   sample      - current sample
//   trig_level  - unsigned threshold
//   trig_rising - EDGE_RISE or EDGE_FALL
//   hit         - combinational: crossing between prev and sample
module trig_detect
    import capture_pkg::*;
(
    input  logic       adc_dco,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       upd,
    input  logic [7:0] sample,
    input  logic [7:0] trig_level,
    input  logic       trig_rising,
    output logic       hit
);

    logic [7:0] prev_q;
    logic       prev_vld_q;
    logic       rise;
    logic       fall;

    always_ff @(posedge adc_dco or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (clr) begin
            prev_vld_q <= 1'b0;
        end else if (upd) begin
            prev_q     <= sample;
            prev_vld_q <= 1'b1;
        end
    end

    always_comb begin
        rise = (prev_q < trig_level) && (sample >= trig_level);
        fall = (prev_q > trig_level) && (sample <= trig_level);
        // No level trigger until a previous sample exists in this capture.
        hit  = prev_vld_q && ((trig_rising == EDGE_RISE) ? rise : fall);
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: arm -> pre-trigger fill -> trigger wait -> post fill -> done sequencer
// driving the write port of a circular sample buffer of DEPTH = 2**ADDR_W.
//   adc_dco, rst_n      - clock, async active-low reset
//   bus (master)        - sample stream in, buffer write port out
//   arm, abort          - start capture (IDLE/DONE only) / return to IDLE (wins over arm)
//   force_trig          - trigger request independent of the comparator
//   trig_level/_rising  - comparator threshold and edge select
//   pretrig_len         - samples kept before the trigger, latched on arm
//   trig_addr           - buffer address of the trigger sample
//   start_addr          - buffer address of the oldest sample in the record
//   busy, done, state   - status; auto_fired - last trigger came from the timeout
// Build option: define CAPTURE_AUTO_TRIG_EN to enable the AUTO_TIMEOUT auto-trigger.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
    input  logic              adc_dco,
    input  logic              rst_n,
    capture_ctrl_if.master    bus,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic [7:0]        trig_level,
    input  logic              trig_rising,
    input  logic [ADDR_W-1:0] pretrig_len,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              auto_fired,
    output logic [2:0]        state
);

    localparam logic [ADDR_W-1:0] AddrMax = '1;  // DEPTH-1

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] p_q, p_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] buf_waddr_q, buf_waddr_d;
    logic [7:0]        buf_wdata_q, buf_wdata_d;
    logic              buf_we_q, buf_we_d;
    logic              auto_fired_q, auto_fired_d;
    logic              force_pend_q, force_pend_d;
    logic              busy_q, done_q;
    logic              wr, clr_prev, level_hit, auto_hit, manual_hit;

    assign wr = bus.sample_valid && !abort && (state_q inside {StPre, StWaitTrig, StPost});
    assign manual_hit = level_hit || force_pend_q || force_trig;

    trig_detect u_trig_detect (
        .adc_dco     (adc_dco),
        .rst_n       (rst_n),
        .clr         (clr_prev),
        .upd         (wr),
        .sample      (bus.sample),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .hit         (level_hit)
    );

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int unsigned   AutoW    = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_TIMEOUT - 1);
    logic [AutoW-1:0] auto_cnt_q;

    // Held at zero outside WAIT_TRIG, so every entry starts a fresh count.
    always_ff @(posedge adc_dco or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_q <= '0;
        end else if (state_q != StWaitTrig) begin
            auto_cnt_q <= '0;
        end else if (bus.sample_valid) begin
            auto_cnt_q <= auto_cnt_q + 1'b1;
        end
    end

    assign auto_hit = (state_q == StWaitTrig) && (auto_cnt_q == AutoLast);
`else
    logic unused_auto_timeout;
    assign unused_auto_timeout = ^AUTO_TIMEOUT;
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        cnt_d        = cnt_q;
        p_d          = p_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        auto_fired_d = auto_fired_q;
        force_pend_d = force_pend_q;
        buf_we_d     = 1'b0;
        buf_waddr_d  = buf_waddr_q;
        buf_wdata_d  = buf_wdata_q;
        clr_prev     = 1'b0;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        waddr_d      = '0;
                        cnt_d        = '0;
                        // An ADDR_W-bit length can never exceed DEPTH-1, so no clamp is needed.
                        p_d          = pretrig_len;
                        auto_fired_d = 1'b0;
                        force_pend_d = 1'b0;
                        clr_prev     = 1'b1;
                        state_d      = (pretrig_len == '0) ? StWaitTrig : StPre;
                    end
                end
                StPre: begin
                    if (force_trig) force_pend_d = 1'b1;
                    if (bus.sample_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == p_q - 1'b1) begin
                            cnt_d   = '0;
                            state_d = StWaitTrig;
                        end
                    end
                end
                StWaitTrig: begin
                    if (force_trig) force_pend_d = 1'b1;
                    if (bus.sample_valid && (manual_hit || auto_hit)) begin
                        trig_addr_d  = waddr_q;
                        start_addr_d = waddr_q - p_q;
                        auto_fired_d = auto_hit && !manual_hit;
                        force_pend_d = 1'b0;
                        cnt_d        = '0;
                        // With P = DEPTH-1 the trigger sample completes the record.
                        state_d      = (p_q == AddrMax) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (bus.sample_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == AddrMax - 1'b1 - p_q) state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (wr) begin
            buf_we_d    = 1'b1;
            buf_waddr_d = waddr_q;
            buf_wdata_d = bus.sample;
            waddr_d     = waddr_q + 1'b1;
        end
    end

    always_ff @(posedge adc_dco or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            waddr_q      <= '0;
            cnt_q        <= '0;
            p_q          <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            auto_fired_q <= 1'b0;
            force_pend_q <= 1'b0;
            buf_we_q     <= 1'b0;
            buf_waddr_q  <= '0;
            buf_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            cnt_q        <= cnt_d;
            p_q          <= p_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            auto_fired_q <= auto_fired_d;
            force_pend_q <= force_pend_d;
            buf_we_q     <= buf_we_d;
            buf_waddr_q  <= buf_waddr_d;
            buf_wdata_q  <= buf_wdata_d;
            busy_q       <= state_d inside {StPre, StWaitTrig, StPost};
            done_q       <= (state_d == StDone);
        end
    end

    assign bus.buf_we    = buf_we_q;
    assign bus.buf_waddr = buf_waddr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign trig_addr     = trig_addr_q;
    assign start_addr    = start_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign auto_fired    = auto_fired_q;
    assign state         = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ADDR_W=4 (DEPTH=16), sample_valid held high.
module tb_capture_ctrl;

    logic       adc_dco = 1'b0;
    logic       rst_n;
    logic       arm, abort, force_trig, trig_rising;
    logic [7:0] trig_level;
    logic [3:0] pretrig_len;
    logic [3:0] trig_addr, start_addr;
    logic       busy, done, auto_fired;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    always #5 adc_dco = ~adc_dco;

    capture_ctrl_if #(.ADDR_W(4)) bus ();

    capture_ctrl #(.ADDR_W(4), .AUTO_TIMEOUT(8)) dut (
        .adc_dco     (adc_dco),
        .rst_n       (rst_n),
        .bus         (bus),
        .arm         (arm),
        .abort       (abort),
        .force_trig  (force_trig),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .pretrig_len (pretrig_len),
        .trig_addr   (trig_addr),
        .start_addr  (start_addr),
        .busy        (busy),
        .done        (done),
        .auto_fired  (auto_fired),
        .state       (state)
    );

    task automatic step();
        @(posedge adc_dco);
        #1;
    endtask

    // One arm edge; the sample present in that cycle must not be written.
    task automatic arm_cap(input logic [3:0] p, input logic [7:0] lvl, input logic rise);
        pretrig_len = p;
        trig_level  = lvl;
        trig_rising = rise;
        bus.sample  = 8'hEE;
        arm         = 1'b1;
        step();
        arm         = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({state, busy, done, auto_fired, bus.buf_we, bus.buf_waddr, bus.buf_wdata,
             trig_addr, start_addr} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs: got st=%0d busy=%b done=%b we=%b wa=%h ta=%h sa=%h want all 0",
                     state, busy, done, bus.buf_we, bus.buf_waddr, trig_addr, start_addr);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        total++;
        if ({state, bus.buf_we} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL idle_no_write: got st=%0d we=%b want st=0 we=0", state, bus.buf_we);
        end
    endtask

    task automatic test_rising();
        arm_cap(4'd4, 8'h80, 1'b1);
        total++;
        if ({state, busy, bus.buf_we} !== {3'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rise_arm: got st=%0d busy=%b we=%b want st=1 busy=1 we=0",
                     state, busy, bus.buf_we);
        end
        for (int k = 0; k < 20; k++) begin
            bus.sample = 8'(k * 16);
            step();
            total++;
            if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata} !== {1'b1, 4'(k), 8'(k * 16)}) begin
                bad++;
                $display("FAIL rise_write k=%0d: got we=%b wa=%h wd=%h want we=1 wa=%h wd=%h",
                         k, bus.buf_we, bus.buf_waddr, bus.buf_wdata, 4'(k), 8'(k * 16));
            end
            if (k == 3) begin
                total++;
                if (state !== 3'd2) begin
                    bad++;
                    $display("FAIL rise_pre_end: got st=%0d want 2", state);
                end
            end
            if (k == 8) begin
                total++;
                if ({state, trig_addr, start_addr} !== {3'd3, 4'd8, 4'd4}) begin
                    bad++;
                    $display("FAIL rise_trig: got st=%0d ta=%h sa=%h want st=3 ta=8 sa=4",
                             state, trig_addr, start_addr);
                end
            end
            if (k == 18) begin
                total++;
                if ({state, done} !== {3'd3, 1'b0}) begin
                    bad++;
                    $display("FAIL rise_post_last_minus1: got st=%0d done=%b want st=3 done=0",
                             state, done);
                end
            end
            if (k == 19) begin
                total++;
                if ({state, done, busy, auto_fired} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL rise_done: got st=%0d done=%b busy=%b af=%b want 4 1 0 0",
                             state, done, busy, auto_fired);
                end
            end
        end
        step();
        total++;
        if ({bus.buf_we, done, trig_addr, start_addr} !== {1'b0, 1'b1, 4'd8, 4'd4}) begin
            bad++;
            $display("FAIL rise_hold: got we=%b done=%b ta=%h sa=%h want we=0 done=1 ta=8 sa=4",
                     bus.buf_we, done, trig_addr, start_addr);
        end
    endtask

    task automatic test_falling();
        arm_cap(4'd0, 8'h40, 1'b0);
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL fall_arm_to_wait: got st=%0d want 2", state);
        end
        for (int k = 0; k < 28; k++) begin
            bus.sample = 8'(255 - 16 * k);
            step();
            total++;
            if ({bus.buf_we, bus.buf_waddr, bus.buf_wdata} !== {1'b1, 4'(k), 8'(255 - 16 * k)}) begin
                bad++;
                $display("FAIL fall_write k=%0d: got we=%b wa=%h wd=%h", k, bus.buf_we,
                         bus.buf_waddr, bus.buf_wdata);
            end
            if (k == 11) begin
                total++;
                if (state !== 3'd2) begin
                    bad++;
                    $display("FAIL fall_no_early_trig: got st=%0d want 2", state);
                end
            end
            if (k == 12) begin
                total++;
                if ({state, trig_addr, start_addr} !== {3'd3, 4'd12, 4'd12}) begin
                    bad++;
                    $display("FAIL fall_trig: got st=%0d ta=%h sa=%h want st=3 ta=c sa=c",
                             state, trig_addr, start_addr);
                end
            end
            if (k == 27) begin
                total++;
                if ({state, done} !== {3'd4, 1'b1}) begin
                    bad++;
                    $display("FAIL fall_done: got st=%0d done=%b want st=4 done=1", state, done);
                end
            end
        end
    endtask

    task automatic test_force();
        arm_cap(4'd4, 8'h80, 1'b1);
        for (int k = 0; k < 16; k++) begin
            bus.sample = 8'h55;
            force_trig = (k == 1);
            step();
            force_trig = 1'b0;
            if (k == 3) begin
                total++;
                if (state !== 3'd2) begin
                    bad++;
                    $display("FAIL force_ignored_in_pre: got st=%0d want 2", state);
                end
            end
            if (k == 4) begin
                total++;
                if ({state, trig_addr, start_addr, auto_fired} !== {3'd3, 4'd4, 4'd0, 1'b0}) begin
                    bad++;
                    $display("FAIL force_trig: got st=%0d ta=%h sa=%h af=%b want 3 4 0 0",
                             state, trig_addr, start_addr, auto_fired);
                end
            end
            if (k == 15) begin
                total++;
                if ({state, done, bus.buf_waddr} !== {3'd4, 1'b1, 4'd15}) begin
                    bad++;
                    $display("FAIL force_done: got st=%0d done=%b wa=%h want 4 1 f",
                             state, done, bus.buf_waddr);
                end
            end
        end
    endtask

    task automatic test_clamp_wrap();
        // 31 does not fit the 4-bit port; all-ones is the DEPTH-1 ceiling it clamps to.
        arm_cap(4'hF, 8'h80, 1'b1);
        for (int k = 0; k < 18; k++) begin
            bus.sample = (k == 17) ? 8'h90 : 8'h10;
            step();
            total++;
            if ({bus.buf_we, bus.buf_waddr} !== {1'b1, 4'(k)}) begin
                bad++;
                $display("FAIL wrap_write k=%0d: got we=%b wa=%h want we=1 wa=%h",
                         k, bus.buf_we, bus.buf_waddr, 4'(k));
            end
            if (k == 14 || k == 16) begin
                total++;
                if (state !== 3'd2) begin
                    bad++;
                    $display("FAIL wrap_wait k=%0d: got st=%0d want 2", k, state);
                end
            end
        end
        total++;
        if ({state, done, trig_addr, start_addr} !== {3'd4, 1'b1, 4'd1, 4'd2}) begin
            bad++;
            $display("FAIL clamp_done: got st=%0d done=%b ta=%h sa=%h want 4 1 1 2",
                     state, done, trig_addr, start_addr);
        end
        step();
        total++;
        if (bus.buf_we !== 1'b0) begin
            bad++;
            $display("FAIL clamp_no_post_write: got we=%b want 0", bus.buf_we);
        end
    endtask

    task automatic test_abort_rearm_reset();
        arm_cap(4'd4, 8'h80, 1'b1);
        for (int k = 0; k < 10; k++) begin
            bus.sample = 8'(k * 16);
            step();
        end
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL abort_setup_post: got st=%0d want 3", state);
        end
        abort      = 1'b1;
        arm        = 1'b1;
        bus.sample = 8'h77;
        step();
        abort = 1'b0;
        arm   = 1'b0;
        total++;
        if ({state, busy, done, bus.buf_we} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL abort_over_arm: got st=%0d busy=%b done=%b we=%b want 0 0 0 0",
                     state, busy, done, bus.buf_we);
        end
        step();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL abort_stays_idle: got st=%0d want 0", state);
        end
        arm_cap(4'd2, 8'h80, 1'b1);
        for (int k = 0; k < 17; k++) begin
            bus.sample = (k == 3) ? 8'hA0 : 8'h00;
            step();
            if (k == 3) begin
                total++;
                if ({state, trig_addr, start_addr} !== {3'd3, 4'd3, 4'd1}) begin
                    bad++;
                    $display("FAIL rearm_trig: got st=%0d ta=%h sa=%h want 3 3 1",
                             state, trig_addr, start_addr);
                end
            end
        end
        total++;
        if ({state, done, bus.buf_waddr} !== {3'd4, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL rearm_done: got st=%0d done=%b wa=%h want 4 1 0",
                     state, done, bus.buf_waddr);
        end
        arm_cap(4'd0, 8'h80, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.sample = 8'h00;
            step();
        end
        total++;
        if ({state, bus.buf_we} !== {3'd2, 1'b1}) begin
            bad++;
            $display("FAIL reset_setup_wait: got st=%0d we=%b want 2 1", state, bus.buf_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({state, busy, done, auto_fired, bus.buf_we, bus.buf_waddr, bus.buf_wdata,
             trig_addr, start_addr} !== 25'd0) begin
            bad++;
            $display("FAIL async_reset: got st=%0d busy=%b we=%b wa=%h ta=%h sa=%h want all 0",
                     state, busy, bus.buf_we, bus.buf_waddr, trig_addr, start_addr);
        end
        #2;
        rst_n = 1'b1;
        step();
        total++;
        if ({state, bus.buf_we} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_idle: got st=%0d we=%b want 0 0", state, bus.buf_we);
        end
    endtask

    task automatic test_auto();
        arm_cap(4'd0, 8'h80, 1'b1);
`ifdef CAPTURE_AUTO_TRIG_EN
        for (int k = 0; k < 8; k++) begin
            bus.sample = 8'h20;
            step();
            if (k == 6) begin
                total++;
                if (state !== 3'd2) begin
                    bad++;
                    $display("FAIL auto_early: got st=%0d want 2", state);
                end
            end
        end
        total++;
        if ({state, trig_addr, start_addr, auto_fired} !== {3'd3, 4'd7, 4'd7, 1'b1}) begin
            bad++;
            $display("FAIL auto_trig: got st=%0d ta=%h sa=%h af=%b want 3 7 7 1",
                     state, trig_addr, start_addr, auto_fired);
        end
`else
        for (int k = 0; k < 20; k++) begin
            bus.sample = 8'h20;
            step();
        end
        total++;
        if ({state, auto_fired} !== {3'd2, 1'b0}) begin
            bad++;
            $display("FAIL no_auto_wait: got st=%0d af=%b want 2 0", state, auto_fired);
        end
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        arm              = 1'b0;
        abort            = 1'b0;
        force_trig       = 1'b0;
        trig_level       = 8'h00;
        trig_rising      = 1'b1;
        pretrig_len      = 4'd0;
        bus.sample_valid = 1'b1;
        bus.sample       = 8'h00;
        test_reset();
        test_rising();
        test_falling();
        test_force();
        test_clamp_wrap();
        test_abort_rearm_reset();
        test_auto();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Trigger and capture sequencer for the scope acquisition path. Consumes the decimated 8-bit sample stream and its one-cycle valid strobe (`decim_clk`) from the ADC acquisition block. Runs the arm → pre-trigger fill → trigger wait → post-trigger fill → done sequence, and drives the write port of a circular sample buffer. Reports where the captured record starts so that readout logic can unroll it.

## Interface

**Parameters**
- `ADDR_W`, default 10: buffer address width. Depth is `DEPTH = 2**ADDR_W`.
- `AUTO_TIMEOUT`, default 4096: number of valid samples spent in WAIT_TRIG before an auto-trigger fires. Used only with `CAPTURE_AUTO_TRIG_EN`.

**Ports**
- `adc_dco` in 1: the only clock, rising edge. All logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe marking a new sample; connects to `decim_clk`.
- `sample` in 8: decimated sample; connects to `adc_data`. Valid when `sample_valid=1`.
- `arm` in 1: start a capture. Level or pulse; sampled only in IDLE and DONE.
- `abort` in 1: return to IDLE from any state.
- `force_trig` in 1: request a trigger independent of the comparator.
- `trig_level` in 8: unsigned trigger threshold.
- `trig_rising` in 1: 1 selects the rising-edge condition, 0 selects falling.
- `pretrig_len` in ADDR_W: number of samples kept before the trigger sample.
- `buf_we` out 1: buffer write enable.
- `buf_waddr` out ADDR_W: buffer write address.
- `buf_wdata` out 8: buffer write data.
- `trig_addr` out ADDR_W: buffer address that holds the trigger sample.
- `start_addr` out ADDR_W: address of the oldest sample in the record.
- `busy` out 1: high in PRE, WAIT_TRIG and POST.
- `done` out 1: high in DONE.
- `auto_fired` out 1: the last trigger came from the timeout.
- `state` out 3: current FSM state, for debug.

## Operation

**States:** IDLE, PRE, WAIT_TRIG, POST, DONE.

**IDLE**
- On `arm`: clear the address counter to 0, clear `auto_fired` and clear the pending force flag.
- Go to PRE. If the effective pretrig length is 0, go directly to WAIT_TRIG.

**Pretrig clamp**
- Effective length `P = min(pretrig_len, DEPTH-1)`.
- `pretrig_len` is latched on arm; later changes do not affect the running capture.

**Writing samples**
- In PRE, WAIT_TRIG and POST, every valid sample is written to `waddr`.
- `waddr` then increments modulo DEPTH, wrapping from DEPTH-1 to 0.

**PRE**
- Counts P writes, then goes to WAIT_TRIG.
- Trigger conditions are ignored. `force_trig` is latched as pending.

**WAIT_TRIG**
- The buffer keeps wrapping.
- The comparator uses `prev`, the previous valid sample. `prev` is updated on every valid sample from PRE onward.
- Rising trigger: `prev < trig_level` and `sample >= trig_level`.
- Falling trigger: `prev > trig_level` and `sample <= trig_level`.
- When P=0, the first sample after arm has no `prev` and cannot trigger on level. It can still trigger via a pending force.
- A valid sample triggers when the level condition holds, OR a force is pending, OR `force_trig` is high in the same cycle.
- On trigger:
  - `trig_addr` takes the address that sample is written to.
  - `start_addr = trig_addr - P` (mod DEPTH).
  - The FSM goes to POST.

**POST**
- Writes `DEPTH-1-P` further samples, then goes to DONE.
- If `DEPTH-1-P` is 0, the FSM goes straight to DONE.
- A full record is DEPTH samples.

**DONE**
- Writes stop.
- `trig_addr` and `start_addr` are held.
- `arm` re-arms the capture exactly as it does from IDLE.

**Abort**
- `abort` → IDLE from any state.
- Abort takes priority over `arm` when both are high in the same cycle.

## Timing

- Reset values: state IDLE; every output 0; `trig_addr=0`; `start_addr=0`.
- All outputs are registered.
- `buf_we`, `buf_waddr` and `buf_wdata` appear one cycle after the `sample_valid` cycle. `buf_we` is a single-cycle pulse.
- State transitions take effect on the clock edge that processes the qualifying sample.
- `done` rises one cycle after the final POST write strobe is issued, i.e. in the same cycle that `buf_we` is high for that write.
- Back-to-back `sample_valid` (every cycle) must be sustained with no sample loss.
- `arm` and the trigger condition are both evaluated on the same edge. A sample that arrives in the arm cycle is not written.
- Asserting `rst_n` low mid-capture forces IDLE immediately and asynchronously. Buffer contents are don't-care after reset.

## Configuration

**With `CAPTURE_AUTO_TRIG_EN` defined**
- A counter runs in WAIT_TRIG and counts valid samples.
- When it reaches `AUTO_TIMEOUT` with no trigger, the current sample is treated as the trigger and `auto_fired` is set to 1.
- The counter clears whenever the FSM enters WAIT_TRIG.

**Without it**
- The FSM waits in WAIT_TRIG indefinitely.
- `auto_fired` is tied to 0.
- No timeout counter is synthesized.

## Structure

- `capture_pkg` holds:
  - the state enum and its 3-bit encoding;
  - constant edge encodings `EDGE_RISE=1` and `EDGE_FALL=0`;
  - the default `AUTO_TIMEOUT`.
- Sub-module `trig_detect` contains:
  - the `prev` register and its valid flag;
  - the rise/fall comparator;
  - a combinational `hit` output.
- The FSM, address and length counters, and the auto-trigger logic stay in `capture_ctrl`.

## Test plan

All scenarios use ADDR_W=4 (DEPTH=16) with `sample_valid` held high.

1. Rising trigger: P=4, level=0x80, ramp 0x00,0x10,… → trigger on the first sample ≥0x80; `trig_addr` = address of that sample; `start_addr=trig_addr-4`; DONE after 11 more writes.
2. Falling trigger: P=0, level=0x40, descending ramp from 0xFF → no trigger on the first sample; trigger on the first sample ≤0x40.
3. Force trigger: `force_trig` pulsed during PRE with a constant input of 0x55 → trigger on the first valid sample in WAIT_TRIG; `auto_fired=0`.
4. Clamp and wrap: `pretrig_len=31` → P=15; POST writes 0; `waddr` wraps from 15 to 0 during WAIT_TRIG; `start_addr=trig_addr+1` (mod 16).
5. Abort, re-arm and reset: `abort` together with `arm` in POST → IDLE, `busy=0`; re-arm completes normally; `rst_n` pulsed low in WAIT_TRIG → all outputs 0 asynchronously.
6. Auto-trigger (`CAPTURE_AUTO_TRIG_EN`, AUTO_TIMEOUT=8): flat input 0x20 → trigger on the 8th valid sample in WAIT_TRIG; `auto_fired=1`.
